sram_arbiter: RTL and testbench

//  Shares the single-port 32-bit sram1rw between instruction fetch and the dcache read/write ports.

---
 rtl/sram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port 32-bit SRAM between instruction fetch,
// dcache reads and dcache stores. Round-robin grant, one SRAM op in flight,
// registered read responses held until consumed, sub-word stores done as
// read-modify-write.
module sram_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [XLEN-1:0]       f_req_addr,
  output logic                  f_rsp_valid,
  input  logic                  f_rsp_ready,
  output logic [31:0]           f_rsp_data,
  input  logic                  d_rd_valid,
  output logic                  d_rd_ready,
  input  logic [XLEN-1:0]       d_rd_addr,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [31:0]           d_rsp_data,
  input  logic                  d_wr_valid,
  output logic                  d_wr_ready,
  input  logic [XLEN-1:0]       d_wr_addr,
  input  logic [31:0]           d_wr_data,
  input  logic [3:0]            d_wr_strb,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_RMW  = 2'd2;

  localparam logic [1:0] PORT_F  = 2'd0;
  localparam logic [1:0] PORT_DR = 2'd1;
  localparam logic [1:0] PORT_DW = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            rr_last_q, rr_last_d;
  logic                  owner_dr_q, owner_dr_d;
  logic                  f_rsp_valid_q, f_rsp_valid_d;
  logic [31:0]           f_rsp_data_q, f_rsp_data_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]           d_rsp_data_q, d_rsp_data_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [31:0]           rmw_data_q, rmw_data_d;
  logic [3:0]            rmw_strb_q, rmw_strb_d;

  logic                  el_f, el_dr, el_dw;
  logic                  gnt_f, gnt_dr, gnt_dw;
  logic [ADDR_WIDTH-1:0] f_idx, dr_idx, dw_idx;
  logic                  unused_addr_bits;

  // Word index: byte-offset bits and bits above the SRAM range are dropped.
  assign f_idx  = f_req_addr[ADDR_WIDTH+1:2];
  assign dr_idx = d_rd_addr[ADDR_WIDTH+1:2];
  assign dw_idx = d_wr_addr[ADDR_WIDTH+1:2];

  assign unused_addr_bits = ^{f_req_addr[XLEN-1:ADDR_WIDTH+2], f_req_addr[1:0],
                              d_rd_addr[XLEN-1:ADDR_WIDTH+2],  d_rd_addr[1:0],
                              d_wr_addr[XLEN-1:ADDR_WIDTH+2],  d_wr_addr[1:0]};

  // A read port is eligible only while its response register is empty;
  // a response draining this cycle still blocks it (one bubble).
  assign el_f  = f_req_valid & ~f_rsp_valid_q;
  assign el_dr = d_rd_valid  & ~d_rsp_valid_q;
  assign el_dw = d_wr_valid;

  // Round-robin grant: first eligible port after the last one granted.
  always_comb begin
    gnt_f  = 1'b0;
    gnt_dr = 1'b0;
    gnt_dw = 1'b0;
    if (state_q == ST_IDLE) begin
      case (rr_last_q)
        PORT_F: begin
          if (el_dr)      gnt_dr = 1'b1;
          else if (el_dw) gnt_dw = 1'b1;
          else if (el_f)  gnt_f  = 1'b1;
        end
        PORT_DR: begin
          if (el_dw)      gnt_dw = 1'b1;
          else if (el_f)  gnt_f  = 1'b1;
          else if (el_dr) gnt_dr = 1'b1;
        end
        default: begin
          if (el_f)       gnt_f  = 1'b1;
          else if (el_dr) gnt_dr = 1'b1;
          else if (el_dw) gnt_dw = 1'b1;
        end
      endcase
    end
  end

  // Next-state, SRAM drive and handshake readies.
  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    owner_dr_d    = owner_dr_q;
    f_rsp_valid_d = f_rsp_valid_q;
    f_rsp_data_d  = f_rsp_data_q;
    d_rsp_valid_d = d_rsp_valid_q;
    d_rsp_data_d  = d_rsp_data_q;
    rmw_addr_d    = rmw_addr_q;
    rmw_data_d    = rmw_data_q;
    rmw_strb_d    = rmw_strb_q;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    f_req_ready   = 1'b0;
    d_rd_ready    = 1'b0;
    d_wr_ready    = 1'b0;

    if (f_rsp_valid_q && f_rsp_ready) f_rsp_valid_d = 1'b0;
    if (d_rsp_valid_q && d_rsp_ready) d_rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_f) begin
          f_req_ready = 1'b1;
          mem_addr    = f_idx;
          owner_dr_d  = 1'b0;
          rr_last_d   = PORT_F;
          state_d     = ST_RD;
        end else if (gnt_dr) begin
          d_rd_ready  = 1'b1;
          mem_addr    = dr_idx;
          owner_dr_d  = 1'b1;
          rr_last_d   = PORT_DR;
          state_d     = ST_RD;
        end else if (gnt_dw) begin
          d_wr_ready  = 1'b1;
          mem_addr    = dw_idx;
          rr_last_d   = PORT_DW;
          if (d_wr_strb == 4'hF) begin
            mem_we    = 1'b1;
            mem_wdata = d_wr_data;
          end else begin
            rmw_addr_d = dw_idx;
            rmw_data_d = d_wr_data;
            rmw_strb_d = d_wr_strb;
            state_d    = ST_RMW;
          end
        end
      end
      ST_RD: begin
        if (owner_dr_q) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = mem_rdata;
        end else begin
          f_rsp_valid_d = 1'b1;
          f_rsp_data_d  = mem_rdata;
        end
        state_d = ST_IDLE;
      end
      ST_RMW: begin
        mem_we   = 1'b1;
        mem_addr = rmw_addr_q;
        for (int unsigned i = 0; i < 4; i++) begin
          mem_wdata[8*i +: 8] = rmw_strb_q[i] ? rmw_data_q[8*i +: 8] : mem_rdata[8*i +: 8];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight read or RMW write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_last_q     <= PORT_DW;
      owner_dr_q    <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      f_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      rmw_addr_q    <= '0;
      rmw_data_q    <= '0;
      rmw_strb_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      owner_dr_q    <= owner_dr_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      f_rsp_data_q  <= f_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
      rmw_addr_q    <= rmw_addr_d;
      rmw_data_q    <= rmw_data_d;
      rmw_strb_q    <= rmw_strb_d;
    end
  end

  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_data  = f_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned AW    = 20;
  localparam int unsigned WORDS = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [XLEN-1:0] f_req_addr;
  logic [31:0]     f_rsp_data;
  logic            d_rd_valid, d_rd_ready, d_rsp_valid, d_rsp_ready;
  logic [XLEN-1:0] d_rd_addr;
  logic [31:0]     d_rsp_data;
  logic            d_wr_valid, d_wr_ready;
  logic [XLEN-1:0] d_wr_addr;
  logic [31:0]     d_wr_data;
  logic [3:0]      d_wr_strb;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  sram_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .d_rd_valid(d_rd_valid), .d_rd_ready(d_rd_ready), .d_rd_addr(d_rd_addr),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_wr_valid(d_wr_valid), .d_wr_ready(d_wr_ready), .d_wr_addr(d_wr_addr),
    .d_wr_data(d_wr_data), .d_wr_strb(d_wr_strb),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment SRAM: write-enable honoured at the edge, read data one cycle later.
  logic [31:0] sram [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: architectural memory, pending responses, arbitration.
  logic [31:0] ref_mem [0:WORDS-1];
  int          last_port;       // 0 fetch, 1 dcache read, 2 dcache store
  bit          busy;            // SRAM occupied by the second cycle of an op
  int          f_wait, d_wait;  // cycles until a granted read's data appears
  bit          m_fv, m_dv;
  logic [31:0] m_fd, m_dd;
  bit          pend;
  int unsigned pend_idx;
  logic [31:0] pend_val;
  bit          f_acc, dr_acc, dw_acc;
  int unsigned grants [0:2];

  function automatic int unsigned widx(input logic [63:0] a);
    return int'((a / 64'd4) % 64'(WORDS));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[21:2] = 20'($urandom % 32);
    return a;
  endfunction

  task automatic model_reset();
    last_port = 2; busy = 0; f_wait = 0; d_wait = 0;
    m_fv = 0; m_dv = 0; m_fd = '0; m_dd = '0; pend = 0;
    f_acc = 0; dr_acc = 0; dw_acc = 0;
  endtask

  function automatic bit eligible(input int p);
    case (p)
      0:       return f_req_valid && !m_fv;
      1:       return d_rd_valid && !m_dv;
      default: return d_wr_valid;
    endcase
  endfunction

  // One clock cycle: checks at the falling edge, retires accepted requests after the rising edge.
  task automatic step();
    int          g;
    bit          exp_we;
    bit          commit;
    int unsigned idx;
    @(negedge clk);
    if (f_wait > 0) begin f_wait--; if (f_wait == 0) m_fv = 1; end
    if (d_wait > 0) begin d_wait--; if (d_wait == 0) m_dv = 1; end
    commit = pend;
    check_eq("f_rsp_valid", f_rsp_valid, m_fv);
    if (m_fv) check_eq("f_rsp_data", f_rsp_data, m_fd);
    check_eq("d_rsp_valid", d_rsp_valid, m_dv);
    if (m_dv) check_eq("d_rsp_data", d_rsp_data, m_dd);

    g = 3;
    if (busy) busy = 0;
    else begin
      for (int k = 1; k <= 3; k++) begin
        if (g == 3 && eligible((last_port + k) % 3)) g = (last_port + k) % 3;
      end
    end
    check_eq("f_req_ready", f_req_ready, g == 0);
    check_eq("d_rd_ready", d_rd_ready, g == 1);
    check_eq("d_wr_ready", d_wr_ready, g == 2);
    exp_we = commit || (g == 2 && d_wr_strb == 4'hF);
    check_eq("mem_we", mem_we, exp_we);

    if (commit) begin
      check_eq("rmw_addr", mem_addr, pend_idx);
      check_eq("rmw_wdata", mem_wdata, pend_val);
      ref_mem[pend_idx] = pend_val;
      pend = 0;
    end

    if (g == 0) begin
      idx = widx(f_req_addr);
      check_eq("f_mem_addr", mem_addr, idx);
      m_fd = ref_mem[idx]; f_wait = 2; busy = 1;
    end else if (g == 1) begin
      idx = widx(d_rd_addr);
      check_eq("dr_mem_addr", mem_addr, idx);
      m_dd = ref_mem[idx]; d_wait = 2; busy = 1;
    end else if (g == 2) begin
      idx = widx(d_wr_addr);
      check_eq("dw_mem_addr", mem_addr, idx);
      if (d_wr_strb == 4'hF) begin
        check_eq("full_wdata", mem_wdata, d_wr_data);
        ref_mem[idx] = d_wr_data;
      end else begin
        pend = 1; pend_idx = idx;
        pend_val = merge(ref_mem[idx], d_wr_data, d_wr_strb);
        busy = 1;
      end
    end
    if (g != 3) begin last_port = g; grants[g]++; end

    if (m_fv && f_rsp_ready) m_fv = 0;
    if (m_dv && d_rsp_ready) m_dv = 0;
    f_acc = (g == 0); dr_acc = (g == 1); dw_acc = (g == 2);

    @(posedge clk); #1;
    if (f_acc)  f_req_valid = 0;
    if (dr_acc) d_rd_valid  = 0;
    if (dw_acc) d_wr_valid  = 0;
  endtask

  task automatic clear_inputs();
    f_req_valid = 0; f_req_addr = '0; f_rsp_ready = 1;
    d_rd_valid = 0; d_rd_addr = '0; d_rsp_ready = 1;
    d_wr_valid = 0; d_wr_addr = '0; d_wr_data = '0; d_wr_strb = 4'hF;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_f_rsp_valid", f_rsp_valid, 0);
    check_eq("rst_d_rsp_valid", d_rsp_valid, 0);
    check_eq("rst_f_rsp_data", f_rsp_data, 0);
    check_eq("rst_d_rsp_data", d_rsp_data, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_readies", {f_req_ready, d_rd_ready, d_wr_ready}, 0);
    rst = 0;
  endtask

  task automatic drive_rand();
    if (!f_req_valid && ($urandom % 2) == 0) begin f_req_valid = 1; f_req_addr = rand_addr(); end
    if (!d_rd_valid && ($urandom % 2) == 0) begin d_rd_valid = 1; d_rd_addr = rand_addr(); end
    if (!d_wr_valid && ($urandom % 2) == 0) begin
      d_wr_valid = 1; d_wr_addr = rand_addr(); d_wr_data = $urandom;
      d_wr_strb = (($urandom % 3) == 0) ? 4'hF : 4'($urandom_range(1, 14));
    end
    f_rsp_ready = ($urandom % 4) != 0;
    d_rsp_ready = ($urandom % 4) != 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    sram[17] = 32'h11223344; ref_mem[17] = 32'h11223344;
    grants[0] = 0; grants[1] = 0; grants[2] = 0;
    do_reset();

    // Fetch of 0x40 reads word 0x10; response from two cycles after grant, held while not consumed.
    f_req_valid = 1; f_req_addr = 64'h40; f_rsp_ready = 0;
    repeat (3) step();
    check_eq("t1_f_data", f_rsp_data, 32'hDEADBEEF);

    // Fetch response stalled: new fetch blocked, dcache read served meanwhile.
    f_req_valid = 1; f_req_addr = 64'h80;
    d_rd_valid = 1; d_rd_addr = 64'h44;
    repeat (4) step();
    check_eq("t4_f_blocked", f_req_valid, 1);
    f_rsp_ready = 1;
    repeat (4) step();

    // Partial store into word 0x11, then read it back.
    d_wr_valid = 1; d_wr_addr = 64'h44; d_wr_strb = 4'b0010; d_wr_data = 32'h0000AB00;
    repeat (2) step();
    d_rd_valid = 1; d_rd_addr = 64'h44;
    repeat (4) step();
    check_eq("t3_readback", d_rsp_data, 32'h1122AB44);

    // Aliased fetch addresses reach the same word.
    f_req_valid = 1; f_req_addr = 64'h40;
    repeat (3) step();
    f_req_valid = 1; f_req_addr = 64'h40 | (64'd1 << 22);
    repeat (3) step();
    check_eq("t6_alias_data", f_rsp_data, 32'hDEADBEEF);

    // All three ports held busy: strict rotation, full-width stores.
    for (int c = 0; c < 18; c++) begin
      if (!f_req_valid) begin f_req_valid = 1; f_req_addr = rand_addr(); end
      if (!d_rd_valid)  begin d_rd_valid = 1; d_rd_addr = rand_addr(); end
      if (!d_wr_valid)  begin
        d_wr_valid = 1; d_wr_addr = rand_addr(); d_wr_data = $urandom; d_wr_strb = 4'hF;
      end
      step();
    end
    clear_inputs();
    repeat (4) step();

    // Reset during the write half of a read-modify-write.
    d_wr_valid = 1; d_wr_addr = 64'h48; d_wr_strb = 4'b1000; d_wr_data = 32'hCC000000;
    step();
    check_eq("t5_rmw_we", mem_we, 1);
    rst = 1;
    #1;
    check_eq("t5_we_drop", mem_we, 0);
    do_reset();
    f_req_valid = 1; f_req_addr = 64'h48;
    d_rd_valid = 1; d_rd_addr = 64'h4C;
    d_wr_valid = 1; d_wr_addr = 64'h50; d_wr_data = 32'h5; d_wr_strb = 4'hF;
    step();
    repeat (8) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      drive_rand();
      step();
    end
    clear_inputs();
    repeat (6) step();

    for (int i = 0; i < 64; i++) check_eq("final_mem", sram[i], ref_mem[i]);
    check_eq("grants_seen", (grants[0] > 100) && (grants[1] > 100) && (grants[2] > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
